// File: rtl/telemetry_tx.sv
// Periodic eBike telemetry transmitter: snapshots battery voltage, motor current and
// pedal torque on a free-running period tick and sends them as an 8-byte 8N1 UART packet.
module telemetry_tx #(
  parameter int BAUD_DIV = 2604,
  parameter int PERIOD_W = 20
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [11:0] batt_v,
  input  logic [11:0] avg_curr,
  input  logic [11:0] avg_torque,
  output logic        TX,
  output logic        busy,
  output logic        pkt_sent
);

  typedef enum logic {
    S_IDLE = 1'b0,
    S_XMIT = 1'b1
  } state_t;

  localparam logic [11:0]         BAUD_LAST  = 12'(BAUD_DIV - 1);
  localparam logic [PERIOD_W-1:0] PERIOD_ONE = {{(PERIOD_W-1){1'b0}}, 1'b1};

  state_t              r_state;
  state_t              w_state_nxt;
  logic [PERIOD_W-1:0] r_period;
  logic [11:0]         r_baud;
  logic [3:0]          r_bit;
  logic [2:0]          r_idx;
  logic [2:0]          w_idx_nxt;
  logic [9:0]          r_shreg;
  logic [9:0]          w_shreg_nxt;
  logic [11:0]         r_batt;
  logic [11:0]         r_curr;
  logic [11:0]         r_torque;
  logic                r_tx;
  logic                r_busy;
  logic                r_pkt_sent;
  logic                w_trigger;
  logic                w_baud_end;
  logic                w_load;
  logic                w_shift;
  logic                w_done;
  logic [7:0]          w_byte;

  function automatic logic [7:0] pkt_byte(input logic [2:0]  idx,
                                          input logic [11:0] b,
                                          input logic [11:0] c,
                                          input logic [11:0] t);
    case (idx)
      3'd0:    pkt_byte = 8'hAA;
      3'd1:    pkt_byte = 8'h55;
      3'd2:    pkt_byte = {4'h0, b[11:8]};
      3'd3:    pkt_byte = b[7:0];
      3'd4:    pkt_byte = {4'h0, c[11:8]};
      3'd5:    pkt_byte = c[7:0];
      3'd6:    pkt_byte = {4'h0, t[11:8]};
      3'd7:    pkt_byte = t[7:0];
      default: pkt_byte = 8'hAA;
    endcase
  endfunction

  assign w_trigger  = &r_period;
  assign w_baud_end = (r_baud == BAUD_LAST);
  // Byte 0 is a constant, so loading it on the trigger edge does not need the snapshot yet.
  assign w_byte     = pkt_byte(w_idx_nxt, r_batt, r_curr, r_torque);

  // Packet FSM: next state, byte index and shift/load/done strobes
  always_comb begin
    w_state_nxt = r_state;
    w_idx_nxt   = r_idx;
    w_load      = 1'b0;
    w_shift     = 1'b0;
    w_done      = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_trigger) begin
          w_state_nxt = S_XMIT;
          w_idx_nxt   = 3'd0;
          w_load      = 1'b1;
        end else begin
          w_state_nxt = S_IDLE;
        end
      end
      S_XMIT: begin
        if (w_baud_end && (r_bit == 4'd9)) begin
          if (r_idx == 3'd7) begin
            w_state_nxt = S_IDLE;
            w_done      = 1'b1;
          end else begin
            w_idx_nxt = r_idx + 3'd1;
            w_load    = 1'b1;
          end
        end else if (w_baud_end) begin
          w_shift = 1'b1;
        end else begin
          w_state_nxt = S_XMIT;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // Shift register next value: frame load {stop, data, start} or right shift filling with idle
  always_comb begin
    w_shreg_nxt = r_shreg;
    if (w_load) begin
      w_shreg_nxt = {1'b1, w_byte, 1'b0};
    end else if (w_shift) begin
      w_shreg_nxt = {1'b1, r_shreg[9:1]};
    end else begin
      w_shreg_nxt = r_shreg;
    end
  end

  // Free-running packet period counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_period <= '0;
    end else begin
      r_period <= r_period + PERIOD_ONE;
    end
  end

  // FSM state, UART datapath and registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= S_IDLE;
      r_idx      <= 3'd0;
      r_shreg    <= 10'h3FF;
      r_baud     <= 12'd0;
      r_bit      <= 4'd0;
      r_batt     <= 12'd0;
      r_curr     <= 12'd0;
      r_torque   <= 12'd0;
      r_tx       <= 1'b1;
      r_busy     <= 1'b0;
      r_pkt_sent <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_idx   <= w_idx_nxt;
      r_shreg <= w_shreg_nxt;
      if ((r_state == S_IDLE) && w_trigger) begin
        r_batt   <= batt_v;
        r_curr   <= avg_curr;
        r_torque <= avg_torque;
      end
      if ((r_state == S_XMIT) && (w_state_nxt == S_XMIT) && !w_baud_end) begin
        r_baud <= r_baud + 12'd1;
      end else begin
        r_baud <= 12'd0;
      end
      if (w_load || w_done) begin
        r_bit <= 4'd0;
      end else if (w_shift) begin
        r_bit <= r_bit + 4'd1;
      end
      // TX follows the next frame bit so the start bit appears right after the trigger edge
      r_tx       <= (w_state_nxt == S_XMIT) ? w_shreg_nxt[0] : 1'b1;
      r_busy     <= (w_state_nxt == S_XMIT);
      r_pkt_sent <= w_done;
    end
  end

  assign TX       = r_tx;
  assign busy     = r_busy;
  assign pkt_sent = r_pkt_sent;

endmodule

// File: tb/tb_telemetry_tx.sv
// Self-checking bench for telemetry_tx: two instances (period 4096 and 1024, 16 clk/bit)
// compared cycle by cycle against a timing model, plus a UART byte decoder on instance A.
module tb_telemetry_tx;

  localparam int BD = 16;
  localparam int PKT_CLKS = 80 * BD;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [11:0] batt_v, avg_curr, avg_torque;
  logic        tx_a, busy_a, sent_a;
  logic        tx_b, busy_b, sent_b;

  telemetry_tx #(.BAUD_DIV(BD), .PERIOD_W(12)) dut_a (
    .clk(clk), .rst_n(rst_n), .batt_v(batt_v), .avg_curr(avg_curr),
    .avg_torque(avg_torque), .TX(tx_a), .busy(busy_a), .pkt_sent(sent_a)
  );

  telemetry_tx #(.BAUD_DIV(BD), .PERIOD_W(10)) dut_b (
    .clk(clk), .rst_n(rst_n), .batt_v(batt_v), .avg_curr(avg_curr),
    .avg_torque(avg_torque), .TX(tx_b), .busy(busy_b), .pkt_sent(sent_b)
  );

  always #5 clk = ~clk;

  int n_total = 0;
  int n_bad   = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // reference model state: edges since reset release, packet start edge and contents
  int          m;
  int          period [2] = '{4096, 1024};
  int          start  [2];
  bit          act    [2];
  logic [63:0] pkt    [2];

  // decoder and gap-measurement state for instance A
  bit         rx_on;
  int         rx_t;
  logic [7:0] rx_sh;
  logic [7:0] rxq [$];
  bit         directed;
  int         n_pk;
  bit         gap_on;
  int         gap;
  logic [7:0] first_bytes [8] = '{8'hAA, 8'h55, 8'h0F, 8'hFF, 8'h01, 8'h23, 8'h07, 8'h00};

  function automatic logic [63:0] make_pkt(input logic [11:0] b, input logic [11:0] c,
                                           input logic [11:0] t);
    return {t[7:0], 4'h0, t[11:8], c[7:0], 4'h0, c[11:8],
            b[7:0], 4'h0, b[11:8], 8'h55, 8'hAA};
  endfunction

  // expected {TX, busy, pkt_sent} after m edges, from packet start time and bit arithmetic
  function automatic logic [2:0] model(input int d);
    int off, k, bi;
    if (!act[d]) return 3'b100;
    off = m - start[d];
    if (off > PKT_CLKS) return 3'b100;
    if (off == PKT_CLKS) return 3'b101;
    k  = off / (10 * BD);
    bi = (off / BD) % 10;
    if (bi == 0) return 3'b010;
    if (bi == 9) return 3'b110;
    return {pkt[d][8*k + bi - 1], 2'b10};
  endfunction

  task automatic reset_model();
    m = 0;
    act = '{1'b0, 1'b0};
    rx_on = 1'b0;
    rxq.delete();
    gap_on = 1'b0;
    n_pk = 0;
  endtask

  task automatic rx_step();
    if (!rx_on) begin
      if (tx_a == 1'b0) begin
        rx_on = 1'b1;
        rx_t  = 0;
      end
    end else begin
      rx_t++;
      if (rx_t >= BD/2 + BD && rx_t <= BD/2 + 8*BD && ((rx_t - BD/2) % BD) == 0) begin
        rx_sh = {tx_a, rx_sh[7:1]};
      end else if (rx_t == BD/2 + 9*BD) begin
        chk("rx_stop", 64'(tx_a), 64'd1);
        rxq.push_back(rx_sh);
        rx_on = 1'b0;
      end
    end
  endtask

  task automatic cycle_check();
    logic [2:0] e, o;
    logic [7:0] eb, gb;
    for (int d = 0; d < 2; d++) begin
      e = model(d);
      o = (d == 0) ? {tx_a, busy_a, sent_a} : {tx_b, busy_b, sent_b};
      chk($sformatf("tx%0d_m%0d", d, m),   64'(o[2]), 64'(e[2]));
      chk($sformatf("busy%0d_m%0d", d, m), 64'(o[1]), 64'(e[1]));
      chk($sformatf("sent%0d_m%0d", d, m), 64'(o[0]), 64'(e[0]));
    end
    rx_step();
    if (model(0) == 3'b101) begin
      chk("rx_count", 64'(rxq.size()), 64'd8);
      for (int k = 0; k < 8; k++) begin
        eb = (directed && n_pk == 0) ? first_bytes[k] : pkt[0][8*k +: 8];
        gb = (k < rxq.size()) ? rxq[k] : ~eb;
        chk($sformatf("rx_byte%0d_pkt%0d", k, n_pk), 64'(gb), 64'(eb));
      end
      rxq.delete();
      n_pk++;
      gap_on = 1'b1;
      gap = 0;
    end else if (gap_on) begin
      if (busy_a == 1'b0) begin
        gap++;
      end else begin
        chk("busy_gap", 64'(gap), 64'(4096 - 1280 - 1));
        gap_on = 1'b0;
      end
    end
  endtask

  // decide whether the coming edge starts a packet, snapshotting the inputs it will see
  task automatic accept();
    logic [2:0] e;
    for (int d = 0; d < 2; d++) begin
      e = model(d);
      if (((m + 1) % period[d]) == 0 && !e[1]) begin
        act[d]   = 1'b1;
        start[d] = m + 1;
        pkt[d]   = make_pkt(batt_v, avg_curr, avg_torque);
      end
    end
  endtask

  task automatic run(input int m_end, input bit rnd);
    while (m < m_end) begin
      cycle_check();
      if (rnd && $urandom_range(63) == 0) begin
        batt_v     = 12'($urandom);
        avg_curr   = 12'($urandom);
        avg_torque = 12'($urandom);
      end
      if (directed && m == 4096 + 500) batt_v = 12'h000;
      accept();
      @(negedge clk);
      m++;
    end
  endtask

  initial begin
    batt_v     = 12'($urandom);
    avg_curr   = 12'($urandom);
    avg_torque = 12'($urandom);
    directed   = 1'b0;
    reset_model();
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    run(4096 + 600, 1'b1);

    // asynchronous reset in the middle of a packet on instance A
    chk("busy_before_rst", 64'(busy_a), 64'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("rst_tx_a",   64'(tx_a),   64'd1);
    chk("rst_busy_a", 64'(busy_a), 64'd0);
    chk("rst_sent_a", 64'(sent_a), 64'd0);
    chk("rst_tx_b",   64'(tx_b),   64'd1);
    chk("rst_busy_b", 64'(busy_b), 64'd0);
    reset_model();
    directed   = 1'b1;
    batt_v     = 12'hFFF;
    avg_curr   = 12'h123;
    avg_torque = 12'h700;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    run(8192 + 1300, 1'b0);
    run(4 * 4096 + 1500, 1'b1);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule

// File: doc/telemetry_tx.md
Name: telemetry_tx

Overview:
Periodic telemetry transmitter for the eBike. It samples battery voltage, average motor current and average pedal torque, frames them into a fixed 8-byte packet, and serializes the packet on TX as 8N1 UART. TX is the signal the top-level eBike drives to the TX pin. The bench decodes it with UART_rcv.

Parameters:
BAUD_DIV, 2604, clocks per UART bit (50 MHz / 19200 baud); legal range 4..4095.
PERIOD_W, 20, width of the free-running packet-period counter; a packet starts every 2^PERIOD_W clocks (top uses 12 when FAST_SIM).

Ports:
clk  in  1  system clock, 50 MHz
rst_n  in  1  asynchronous active-low reset
batt_v  in  12  battery voltage from A2D interface
avg_curr  in  12  averaged motor current
avg_torque  in  12  averaged pedal torque
TX  out  1  serial output, idle high
busy  out  1  high while a packet is in flight
pkt_sent  out  1  one-clock pulse when the last stop bit of a packet completes

Behaviour:
- Reset (asynchronous, rst_n low): TX=1, busy=0, pkt_sent=0. The period counter, baud counter, bit counter and byte index all clear. The FSM goes to IDLE.
- Reset mid-packet: TX returns to 1 immediately. The partial packet is abandoned, not resumed.
- Period counter: PERIOD_W bits, free-running, increments every clk, wraps to 0.
  - Trigger = counter at all-ones.
  - A trigger while busy=1 is dropped, not queued.
- Snapshot: on the trigger clock with busy=0, batt_v, avg_curr and avg_torque are registered. Packet contents never change mid-packet.
- Packet byte order:
  - B0 = 0xAA, B1 = 0x55
  - B2 = {4'h0, batt[11:8]}, B3 = batt[7:0]
  - B4 = {4'h0, curr[11:8]}, B5 = curr[7:0]
  - B6 = {4'h0, torque[11:8]}, B7 = torque[7:0]
- Packet FSM states:
  - IDLE: waits for trigger. On trigger, loads B0, sets byte index to 0, goes to XMIT. busy goes high the cycle after the trigger.
  - XMIT: the UART engine sends the current byte.
    - When the stop bit ends and byte index < 7: increment the index, load the next byte, stay in XMIT.
    - When the stop bit ends and byte index = 7: go to IDLE, pulse pkt_sent for one clk. busy drops in the same cycle as pkt_sent.
- UART engine, 8N1, LSB first:
  - Frame = start(0), d0..d7, stop(1); each bit lasts exactly BAUD_DIV clocks.
  - The start bit of B0 appears on TX the cycle after the trigger.
  - There is no idle gap between bytes: the next start bit begins on the clock after the previous stop bit's BAUD_DIV clocks.
  - Packet length = 80*BAUD_DIV clocks, from first start bit to pkt_sent.
- Implementation structure:
  - 10-bit shift register, loaded {1'b1, byte, 1'b0} and shifted right.
  - TX registered from shreg[0] (glitch-free).
  - Baud counter (12 bits) counts 0..BAUD_DIV-1.
  - Bit counter counts 0..9.
- TX is 1 whenever busy=0.
- If 2^PERIOD_W < 80*BAUD_DIV, every other trigger (or more) is dropped. This is legal; no error output.

Test Plan:
1. Reset with BAUD_DIV=16, PERIOD_W=12, held mid-packet → TX=1, busy=0, pkt_sent=0 immediately. Counter restarts, and the first packet starts 4096 clks after reset release.
2. batt_v=0xFFF, avg_curr=0x123, avg_torque=0x700 → UART_rcv (matching baud) receives, in order: AA 55 0F FF 01 23 07 00. pkt_sent pulses exactly 1280 clks after the first start-bit edge.
3. Bit timing → TX falling edge one clk after trigger. Each bit is exactly 16 clks. Stop bit of B0 is followed directly by the start bit of B1, with no idle clocks.
4. Change batt_v from 0xFFF to 0x000 mid-packet → the current packet still sends 0F FF. The next packet sends 00 00.
5. PERIOD_W=10, BAUD_DIV=16 (period 1024 < packet 1280) → the second trigger is dropped. Packets start every 2048 clks, and each packet stays intact.
6. Back-to-back packets with PERIOD_W=12 → busy is low for exactly 4096−1280−1 clks between packets, and TX stays 1 throughout.
